clusterv_tile_sram_initiator: RTL

- Initiator-side bridge that converts a valid/ready request/response channel into the generic byte-enable SRAM port.
- Drives addr, read/write enables, byte enables and write data, and captures read data one cycle after issue.
- Returns every access, read or write, as an in-order response through a RSP_DEPTH-entry buffer, so responses can be back-pressured without losing data.
- Sits between a tile master (core or DMA) and the tile SRAM target wrapper.

---
 rtl/clusterv_tile_sram_initiator_if.sv | 35 +++
 rtl/clusterv_tile_sram_initiator.sv | 76 +++++++
 2 files changed

// File: rtl/clusterv_tile_sram_initiator_if.sv
// clusterv_tile_sram_initiator_if: request/response channel plus byte-enable SRAM port.
// The master modport is the environment side: the tile master and the SRAM read-data return.
interface clusterv_tile_sram_initiator_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_strb;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_write;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic                    i_read_en;
    logic                    i_write_en;
    logic [DATA_WIDTH/8-1:0] i_byte_en;
    logic [DATA_WIDTH-1:0]   i_write_data;
    logic [DATA_WIDTH-1:0]   i_read_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready, i_read_data,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata,
        input  i_addr, i_read_en, i_write_en, i_byte_en, i_write_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready, i_read_data,
        output req_ready, rsp_valid, rsp_write, rsp_rdata,
        output i_addr, i_read_en, i_write_en, i_byte_en, i_write_data
    );
endinterface

// File: rtl/clusterv_tile_sram_initiator.sv
// clusterv_tile_sram_initiator: valid/ready request channel to byte-enable SRAM port,
// every access acknowledged in order through a RSP_DEPTH-entry response FIFO.
module clusterv_tile_sram_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 3
) (
    input logic clock,
    input logic reset,
    clusterv_tile_sram_initiator_if.slave bus_if
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_write_q, s1_write_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  fifo_write_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_rdata_q [RSP_DEPTH];
    logic [CW:0]           outst;
    logic                  fire, push, pop;

    // Credit rule: the access in the SRAM stage already owns a FIFO slot, so no overflow
    assign outst            = (CW+1)'(count_q) + (CW+1)'(s1_valid_q);
    assign bus_if.req_ready = !reset && (outst < (CW+1)'(RSP_DEPTH));
    assign fire             = bus_if.req_valid && bus_if.req_ready;

    assign bus_if.i_read_en    = fire && !bus_if.req_write;
    assign bus_if.i_write_en   = fire && bus_if.req_write;
    assign bus_if.i_addr       = fire ? bus_if.req_addr : '0;
    assign bus_if.i_write_data = bus_if.i_write_en ? bus_if.req_wdata : '0;
    assign bus_if.i_byte_en    = !fire ? '0 : bus_if.req_write ? bus_if.req_strb : {SW{1'b1}};

    assign push = s1_valid_q;
    assign pop  = bus_if.rsp_valid && bus_if.rsp_ready;

    // Head is gated so stale entries never show once the FIFO is empty
    assign bus_if.rsp_valid = count_q != '0;
    assign bus_if.rsp_write = bus_if.rsp_valid && fifo_write_q[rd_ptr_q];
    assign bus_if.rsp_rdata = bus_if.rsp_valid ? fifo_rdata_q[rd_ptr_q] : '0;

    always_comb begin
        s1_valid_d = fire;
        s1_write_d = bus_if.req_write;
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = !push ? wr_ptr_q : (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d   = !pop ? rd_ptr_q : (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_write_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_write_q <= s1_write_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // SRAM read data is valid exactly in the stage-1 cycle, so it is captured straight into the FIFO
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_write_q[wr_ptr_q] <= s1_write_q;
            fifo_rdata_q[wr_ptr_q] <= s1_write_q ? '0 : bus_if.i_read_data;
        end
    end
endmodule
